// File: rtl/tdm_pkg.sv
// Shared definitions for the four-slot TDM link, used by both the demultiplexer
// and the matching transmitter.
package tdm_pkg;

    localparam int TDM_SLOTS = 4;

    typedef logic [1:0] tdm_slot_t;

    typedef enum logic {
        TDM_HUNT   = 1'b0,
        TDM_LOCKED = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Stream-side and frame-side signals of the four-channel TDM demultiplexer.
// The master drives the incoming stream; the slave presents the recovered frame.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    tdm_slot_t        s;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, in_valid, frame_sync,
        input  a, b, c, d, s, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, in_valid, frame_sync,
        output a, b, c, d, s, frame_valid, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Two-bit slot counter: loads 0 or 1 on i_load (which wins over i_inc),
// otherwise counts up on i_inc and wraps 3 -> 0.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_inc,
    input  logic      i_load,
    input  logic      i_load_val,
    output tdm_slot_t o_slot
);

    tdm_slot_t r_slot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot <= {1'b0, i_load_val};
        end else if (i_inc) begin
            r_slot <= r_slot + 2'd1;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: recovers frame alignment from frame_sync, stages
// slots 0..2 and publishes all four channels together when slot 3 arrives.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
)(
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    tdm_state_t       r_state;
    logic [WIDTH-1:0] r_stg0;
    logic [WIDTH-1:0] r_stg1;
    logic [WIDTH-1:0] r_stg2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic             r_frame_valid;
    logic             r_sync_err;

    tdm_slot_t        w_slot;
    logic             w_inc;
    logic             w_load;
    logic             w_load_val;

    // Any accepted sync starts a new frame (slot 1 next); a missing sync clears to 0.
    always_comb begin
        w_inc      = 1'b0;
        w_load     = 1'b0;
        w_load_val = 1'b0;
        if (bus.in_valid) begin
            if (bus.frame_sync) begin
                w_load     = 1'b1;
                w_load_val = 1'b1;
            end else if (r_state == TDM_LOCKED) begin
                if (w_slot == 2'd0) begin
                    w_load = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
        end
    end

    tdm_slot_ctr u_slot_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_inc),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_slot     (w_slot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= TDM_HUNT;
            r_stg0        <= '0;
            r_stg1        <= '0;
            r_stg2        <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (bus.in_valid) begin
                case (r_state)
                    TDM_HUNT: begin
                        if (bus.frame_sync) begin
                            r_stg0  <= bus.din;
                            r_state <= TDM_LOCKED;
                        end
                    end
                    TDM_LOCKED: begin
                        if (bus.frame_sync) begin
                            // Early sync abandons the partial frame but keeps lock.
                            r_stg0     <= bus.din;
                            r_sync_err <= (w_slot != 2'd0);
                        end else begin
                            case (w_slot)
                                2'd0: begin
                                    r_sync_err <= 1'b1;
                                    r_state    <= TDM_HUNT;
                                end
                                2'd1: r_stg1 <= bus.din;
                                2'd2: r_stg2 <= bus.din;
                                default: begin
                                    r_a           <= r_stg0;
                                    r_b           <= r_stg1;
                                    r_c           <= r_stg2;
                                    r_d           <= bus.din;
                                    r_frame_valid <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: r_state <= TDM_HUNT;
                endcase
            end
        end
    end

    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.c           = r_c;
    assign bus.d           = r_d;
    assign bus.s           = w_slot;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = (r_state == TDM_LOCKED);
    assign bus.sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table for the listed scenarios, then
// random framed traffic with injected sync faults against a frame-level model.
module tb_tdm_demux4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         iv;
        logic         fs;
        logic [W-1:0] din;
        logic [W-1:0] a, b, c, d;
        logic [1:0]   s;
        logic         fv, lk, err;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic V(input logic r, input logic iv, input logic fs, input logic [W-1:0] din,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                     input logic [W-1:0] d, input logic [1:0] s, input logic fv,
                     input logic lk, input logic err);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.fs = fs; v.din = din;
        v.a = a; v.b = b; v.c = c; v.d = d; v.s = s; v.fv = fv; v.lk = lk; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic compare(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d, input logic [1:0] s,
                           input logic fv, input logic lk, input logic err);
        logic [4*W+4:0] act, exp;
        act = {bus.a, bus.b, bus.c, bus.d, bus.s, bus.frame_valid, bus.locked, bus.sync_err};
        exp = {a, b, c, d, s, fv, lk, err};
        checks++;
        if (act !== exp || (bus.frame_valid && bus.sync_err)) begin
            errors++;
            $display("FAIL %s: got abcd=%h%h%h%h s=%0d fv=%b lk=%b err=%b, want abcd=%h%h%h%h s=%0d fv=%b lk=%b err=%b",
                     name, bus.a, bus.b, bus.c, bus.d, bus.s, bus.frame_valid, bus.locked,
                     bus.sync_err, a, b, c, d, s, fv, lk, err);
        end
    endtask

    // Frame-level model: partial frame kept as a queue of accepted samples.
    logic         m_locked;
    logic [W-1:0] m_part[$];
    logic [W-1:0] m_a, m_b, m_c, m_d;
    logic         m_fv, m_err;

    task automatic model_step(input logic r, input logic iv, input logic fs, input logic [W-1:0] din);
        m_fv = 1'b0; m_err = 1'b0;
        if (!r) begin
            m_locked = 1'b0; m_part.delete();
            m_a = '0; m_b = '0; m_c = '0; m_d = '0;
        end else if (iv) begin
            if (fs) begin
                m_err = m_locked && (m_part.size() != 0);
                m_locked = 1'b1;
                m_part.delete();
                m_part.push_back(din);
            end else if (m_locked) begin
                if (m_part.size() == 0) begin
                    m_err = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_part.push_back(din);
                    if (m_part.size() == 4) begin
                        m_a = m_part[0]; m_b = m_part[1]; m_c = m_part[2]; m_d = m_part[3];
                        m_fv = 1'b1;
                        m_part.delete();
                    end
                end
            end
        end
    endtask

    initial begin
        int tx_slot;
        logic r, iv, fs;
        logic [W-1:0] din;

        rst_n = 1'b0; bus.in_valid = 1'b0; bus.frame_sync = 1'b0; bus.din = '0;

        // Reset held with active-looking input
        V(0,1,1,4'h7, 0,0,0,0, 0,0,0,0);
        V(0,1,0,4'hC, 0,0,0,0, 0,0,0,0);
        // Aligned frame, then a frame with idles after slot 1
        V(1,1,1,4'h1, 0,0,0,0, 1,0,1,0);
        V(1,1,0,4'h2, 0,0,0,0, 2,0,1,0);
        V(1,1,0,4'h3, 0,0,0,0, 3,0,1,0);
        V(1,1,0,4'h4, 1,2,3,4, 0,1,1,0);
        V(1,1,1,4'h5, 1,2,3,4, 1,0,1,0);
        V(1,1,0,4'h6, 1,2,3,4, 2,0,1,0);
        V(1,0,1,4'hF, 1,2,3,4, 2,0,1,0);
        V(1,0,0,4'hE, 1,2,3,4, 2,0,1,0);
        V(1,1,0,4'h7, 1,2,3,4, 3,0,1,0);
        V(1,1,0,4'h8, 5,6,7,8, 0,1,1,0);
        // HUNT discard
        V(0,1,1,4'h3, 0,0,0,0, 0,0,0,0);
        V(1,1,0,4'hA, 0,0,0,0, 0,0,0,0);
        V(1,1,0,4'hB, 0,0,0,0, 0,0,0,0);
        V(1,1,1,4'h1, 0,0,0,0, 1,0,1,0);
        V(1,1,0,4'h2, 0,0,0,0, 2,0,1,0);
        V(1,1,0,4'h3, 0,0,0,0, 3,0,1,0);
        V(1,1,0,4'h4, 1,2,3,4, 0,1,1,0);
        // Early sync
        V(1,1,1,4'h9, 1,2,3,4, 1,0,1,0);
        V(1,1,0,4'hC, 1,2,3,4, 2,0,1,0);
        V(1,1,1,4'h5, 1,2,3,4, 1,0,1,1);
        V(1,1,0,4'h6, 1,2,3,4, 2,0,1,0);
        V(1,1,0,4'h7, 1,2,3,4, 3,0,1,0);
        V(1,1,0,4'h8, 5,6,7,8, 0,1,1,0);
        // Missing sync, then relock
        V(1,1,0,4'hE, 5,6,7,8, 0,0,0,1);
        V(1,1,1,4'h1, 5,6,7,8, 1,0,1,0);
        V(1,1,0,4'h2, 5,6,7,8, 2,0,1,0);
        V(1,1,0,4'h3, 5,6,7,8, 3,0,1,0);
        V(1,1,0,4'h4, 1,2,3,4, 0,1,1,0);
        // Reset mid-frame
        V(1,1,1,4'h1, 1,2,3,4, 1,0,1,0);
        V(1,1,0,4'h2, 1,2,3,4, 2,0,1,0);
        V(0,0,0,4'h0, 0,0,0,0, 0,0,0,0);
        V(1,1,0,4'h3, 0,0,0,0, 0,0,0,0);
        V(1,1,0,4'h4, 0,0,0,0, 0,0,0,0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n;
            bus.in_valid = tbl[i].iv;
            bus.frame_sync = tbl[i].fs;
            bus.din = tbl[i].din;
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
                    tbl[i].s, tbl[i].fv, tbl[i].lk, tbl[i].err);
        end

        // Back-to-back frames straight after reset, no idles
        rst_n = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                bus.in_valid = 1'b1;
                bus.frame_sync = (k == 0);
                bus.din = 4'(f * 4 + k + 1);
                @(posedge clk); #1;
            end
            compare($sformatf("b2b%0d", f), 4'(f*4+1), 4'(f*4+2), 4'(f*4+3), 4'(f*4+4),
                    2'd0, 1'b1, 1'b1, 1'b0);
        end

        // Randomized traffic against the model
        m_locked = 1'b0; m_part.delete();
        m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_fv = 1'b0; m_err = 1'b0;
        rst_n = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        tx_slot = 0;
        for (int n = 0; n < 2000; n++) begin
            r   = ($urandom_range(0, 199) != 0);
            iv  = ($urandom_range(0, 3) != 0);
            fs  = (tx_slot == 0);
            if ($urandom_range(0, 15) == 0) fs = ~fs;
            din = W'($urandom);
            if (!iv) fs = W'($urandom) > 7;
            rst_n = r; bus.in_valid = iv; bus.frame_sync = fs; bus.din = din;
            if (iv) tx_slot = (tx_slot + 1) % 4;
            @(posedge clk);
            model_step(r, iv, fs, din);
            #1;
            compare($sformatf("rnd%0d", n), m_a, m_b, m_c, m_d, 2'(m_part.size()),
                    m_fv, m_locked, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
